// File: rtl/cc_level_sequencer.sv
// rtl/cc_level_sequencer.sv - Frogger level sequencer: load/play/pause/win/lose with per-level speed
// Optional lives feature: define CC_LEVEL_SEQUENCER_LIVES_EN.
module cc_level_sequencer #(
    parameter int LEVEL_WIDTH = 5,
    parameter int MAX_LEVEL   = 5,
    parameter int PAUSE_TICKS = 8,
    parameter int SPEED_WIDTH = 8,
    parameter int SPEED_BASE  = 20,
    parameter int SPEED_STEP  = 3,
    parameter int LIVES       = 3
) (
    input  logic                   CC_LEVEL_SEQUENCER_CLOCK_50,
    input  logic                   CC_LEVEL_SEQUENCER_RESET_InHigh,
    input  logic                   CC_LEVEL_SEQUENCER_start_InLow,
    input  logic                   CC_LEVEL_SEQUENCER_goal_InHigh,
    input  logic                   CC_LEVEL_SEQUENCER_crash_InHigh,
    input  logic                   CC_LEVEL_SEQUENCER_tick_InHigh,
    output logic [LEVEL_WIDTH-1:0] CC_LEVEL_SEQUENCER_level_Out,
    output logic [SPEED_WIDTH-1:0] CC_LEVEL_SEQUENCER_speed_Out,
    output logic                   CC_LEVEL_SEQUENCER_load_OutHigh,
    output logic                   CC_LEVEL_SEQUENCER_play_OutHigh,
    output logic                   CC_LEVEL_SEQUENCER_win_OutHigh,
    output logic                   CC_LEVEL_SEQUENCER_lose_OutHigh,
    output logic [1:0]             CC_LEVEL_SEQUENCER_lives_Out
);
    localparam int PCW = $clog2(PAUSE_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PLAY, S_PAUSE, S_WIN, S_LOSE
    } state_t;

    state_t                 state, state_next;
    logic [LEVEL_WIDTH-1:0] level, level_next;
    logic [PCW-1:0]         pause_cnt, pause_cnt_next;
    logic [SPEED_WIDTH-1:0] speed, speed_next;
    logic                   load, play, win, lose;
    logic                   start;
    int                     spd;

    assign start = ~CC_LEVEL_SEQUENCER_start_InLow;

`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
    logic [1:0] lives, lives_next;
    assign CC_LEVEL_SEQUENCER_lives_Out = lives;
`else
    assign CC_LEVEL_SEQUENCER_lives_Out = 2'(LIVES);
`endif

    always_comb begin
        state_next     = state;
        level_next     = level;
        pause_cnt_next = pause_cnt;
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
        lives_next     = lives;
`endif
        // Speed follows the registered level, so it settles one cycle after a level change.
        spd        = SPEED_BASE - ($signed(32'(level)) - 1) * SPEED_STEP;
        speed_next = (spd < 1) ? SPEED_WIDTH'(1) : SPEED_WIDTH'(spd);

        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_LOAD;
            end
            S_LOAD: state_next = S_PLAY;
            S_PLAY: begin
                if (CC_LEVEL_SEQUENCER_crash_InHigh) begin
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
                    if (lives > 2'd1) begin
                        lives_next = lives - 2'd1;
                        state_next = S_LOAD;
                    end else begin
                        lives_next = 2'd0;
                        state_next = S_LOSE;
                    end
`else
                    state_next = S_LOSE;
`endif
                end else if (CC_LEVEL_SEQUENCER_goal_InHigh) begin
                    if (level == LEVEL_WIDTH'(MAX_LEVEL)) begin
                        state_next = S_WIN;
                    end else begin
                        level_next     = level + LEVEL_WIDTH'(1);
                        pause_cnt_next = '0;
                        state_next     = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (CC_LEVEL_SEQUENCER_tick_InHigh) begin
                    pause_cnt_next = pause_cnt + PCW'(1);
                    if (pause_cnt == PCW'(PAUSE_TICKS - 1))
                        state_next = S_LOAD;
                end
            end
            S_WIN, S_LOSE: begin
                if (start) begin
                    level_next = LEVEL_WIDTH'(1);
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
                    lives_next = 2'(LIVES);
`endif
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50) begin
        if (CC_LEVEL_SEQUENCER_RESET_InHigh) begin
            state     <= S_IDLE;
            level     <= LEVEL_WIDTH'(1);
            pause_cnt <= '0;
            speed     <= SPEED_WIDTH'(SPEED_BASE);
            load      <= 1'b0;
            play      <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
            lives     <= 2'(LIVES);
`endif
        end else begin
            state     <= state_next;
            level     <= level_next;
            pause_cnt <= pause_cnt_next;
            speed     <= speed_next;
            // Flags decoded from the next state so they are true registers aligned with the state.
            load      <= (state_next == S_LOAD);
            play      <= (state_next == S_PLAY);
            win       <= (state_next == S_WIN);
            lose      <= (state_next == S_LOSE);
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
            lives     <= lives_next;
`endif
        end
    end

    assign CC_LEVEL_SEQUENCER_level_Out    = level;
    assign CC_LEVEL_SEQUENCER_speed_Out    = speed;
    assign CC_LEVEL_SEQUENCER_load_OutHigh = load;
    assign CC_LEVEL_SEQUENCER_play_OutHigh = play;
    assign CC_LEVEL_SEQUENCER_win_OutHigh  = win;
    assign CC_LEVEL_SEQUENCER_lose_OutHigh = lose;
endmodule

// File: tb/tb_cc_level_sequencer.sv
// tb/tb_cc_level_sequencer.sv - table, directed and random checks for cc_level_sequencer
module tb_cc_level_sequencer;
    localparam int MAX_LEVEL   = 5;
    localparam int PAUSE_TICKS = 8;
    localparam int SPEED_BASE  = 20;
    localparam int SPEED_STEP  = 3;
    localparam int LIVES       = 3;

    logic       clk = 1'b0;
    logic       rst, start_n, goal, crash, tick;
    logic [4:0] level;
    logic [7:0] speed;
    logic       load, play, win, lose;
    logic [1:0] lives;

    int n_total = 0;
    int n_pass  = 0;

    cc_level_sequencer dut (
        .CC_LEVEL_SEQUENCER_CLOCK_50     (clk),
        .CC_LEVEL_SEQUENCER_RESET_InHigh (rst),
        .CC_LEVEL_SEQUENCER_start_InLow  (start_n),
        .CC_LEVEL_SEQUENCER_goal_InHigh  (goal),
        .CC_LEVEL_SEQUENCER_crash_InHigh (crash),
        .CC_LEVEL_SEQUENCER_tick_InHigh  (tick),
        .CC_LEVEL_SEQUENCER_level_Out    (level),
        .CC_LEVEL_SEQUENCER_speed_Out    (speed),
        .CC_LEVEL_SEQUENCER_load_OutHigh (load),
        .CC_LEVEL_SEQUENCER_play_OutHigh (play),
        .CC_LEVEL_SEQUENCER_win_OutHigh  (win),
        .CC_LEVEL_SEQUENCER_lose_OutHigh (lose),
        .CC_LEVEL_SEQUENCER_lives_Out    (lives)
    );

    always #10 clk = ~clk;

    // Reference model: game phase, level, remaining pause ticks, lives, expected speed.
    typedef enum int {M_IDLE, M_LOAD, M_PLAY, M_PAUSE, M_WIN, M_LOSE} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_lvl = 1, m_ticks_left = 0, m_lives = LIVES, m_spd = SPEED_BASE;

    function automatic int speed_of(input int l);
        int s;
        s = SPEED_BASE - (l - 1) * SPEED_STEP;
        return (s < 1) ? 1 : s;
    endfunction

    task automatic model_step(input logic r, input logic sn, input logic g, input logic c, input logic t);
        int prev_lvl;
        prev_lvl = m_lvl;
        if (r) begin
            m_mode = M_IDLE; m_lvl = 1; m_ticks_left = 0; m_lives = LIVES; m_spd = SPEED_BASE;
            return;
        end
        m_spd = speed_of(prev_lvl);
        if (m_mode == M_IDLE) begin
            if (!sn) m_mode = M_LOAD;
        end else if (m_mode == M_LOAD) begin
            m_mode = M_PLAY;
        end else if (m_mode == M_PLAY) begin
            if (c) begin
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
                m_lives = m_lives - 1;
                m_mode  = (m_lives == 0) ? M_LOSE : M_LOAD;
`else
                m_mode = M_LOSE;
`endif
            end else if (g) begin
                if (m_lvl >= MAX_LEVEL) m_mode = M_WIN;
                else begin
                    m_lvl = m_lvl + 1;
                    m_ticks_left = PAUSE_TICKS;
                    m_mode = M_PAUSE;
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (t) begin
                m_ticks_left = m_ticks_left - 1;
                if (m_ticks_left == 0) m_mode = M_LOAD;
            end
        end else begin
            if (!sn) begin
                m_lvl = 1; m_lives = LIVES; m_mode = M_LOAD;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cycle(input logic r, input logic sn, input logic g, input logic c, input logic t);
        rst = r; start_n = sn; goal = g; crash = c; tick = t;
        @(posedge clk);
        model_step(r, sn, g, c, t);
        #1;
        chk("model_level", int'(level), m_lvl);
        chk("model_speed", int'(speed), m_spd);
        chk("model_load",  int'(load),  int'(m_mode == M_LOAD));
        chk("model_play",  int'(play),  int'(m_mode == M_PLAY));
        chk("model_win",   int'(win),   int'(m_mode == M_WIN));
        chk("model_lose",  int'(lose),  int'(m_mode == M_LOSE));
        chk("model_lives", int'(lives), m_lives);
        rst = 1'b0; start_n = 1'b1; goal = 1'b0; crash = 1'b0; tick = 1'b0;
    endtask

    task automatic advance_level();
        cycle(0, 1, 1, 0, 0);
        for (int k = 0; k < PAUSE_TICKS; k++) cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
    endtask

    typedef struct {
        logic r, sn, g, c, t;
        int   lvl;
        logic ld, pl, wn, ls;
        int   spd;
    } vec_t;

    vec_t vt[15];

    initial begin
        rst = 1'b1; start_n = 1'b1; goal = 1'b0; crash = 1'b0; tick = 1'b0;

        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 20};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 20};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 20};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 20};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 20};
        for (int i = 5; i < 12; i++)
            vt[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        vt[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        vt[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 17};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 17};

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            cycle(vt[i].r, vt[i].sn, vt[i].g, vt[i].c, vt[i].t);
            chk($sformatf("vec%0d_level", i), int'(level), vt[i].lvl);
            chk($sformatf("vec%0d_load", i),  int'(load),  int'(vt[i].ld));
            chk($sformatf("vec%0d_play", i),  int'(play),  int'(vt[i].pl));
            chk($sformatf("vec%0d_win", i),   int'(win),   int'(vt[i].wn));
            chk($sformatf("vec%0d_lose", i),  int'(lose),  int'(vt[i].ls));
            chk($sformatf("vec%0d_speed", i), int'(speed), vt[i].spd);
        end

        // Clear up to the final level and win.
        for (int l = 2; l < MAX_LEVEL; l++) advance_level();
        chk("lvl5_level", int'(level), 5);
        chk("lvl5_speed", int'(speed), 8);
        cycle(0, 1, 1, 0, 0);
        chk("win_flag", int'(win), 1);
        chk("win_level_held", int'(level), 5);
        cycle(0, 1, 1, 1, 1);
        chk("win_sticky", int'(win), 1);
        cycle(0, 0, 0, 0, 0);
        chk("restart_level", int'(level), 1);
        chk("restart_load", int'(load), 1);
        chk("restart_win_clear", int'(win), 0);
        cycle(0, 1, 0, 0, 0);
        advance_level();

        // Goal and crash together at level 2: crash wins.
        cycle(0, 1, 1, 1, 0);
`ifdef CC_LEVEL_SEQUENCER_LIVES_EN
        chk("gc_lives", int'(lives), 2);
        chk("gc_load", int'(load), 1);
        chk("gc_level", int'(level), 2);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        chk("crash2_lives", int'(lives), 1);
        chk("crash2_load", int'(load), 1);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        chk("crash3_lives", int'(lives), 0);
        chk("crash3_lose", int'(lose), 1);
        chk("crash3_noload", int'(load), 0);
`else
        chk("gc_lose", int'(lose), 1);
        chk("gc_level", int'(level), 2);
        chk("gc_lives_tied", int'(lives), LIVES);
`endif
        cycle(0, 0, 0, 0, 0);
        chk("lose_restart_load", int'(load), 1);
        cycle(0, 1, 0, 0, 0);

        // Reset during the 4th pause tick.
        cycle(0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        chk("rst_pause_level", int'(level), 1);
        chk("rst_pause_play", int'(play), 0);
        chk("rst_pause_load", int'(load), 0);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 1, 0);
        chk("idle_hold_load", int'(load), 0);
        chk("idle_hold_play", int'(play), 0);

        // Random stimulus against the model.
        cycle(1, 1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            cycle(logic'($urandom_range(0, 199) == 0),
                  logic'($urandom_range(0, 11) != 0),
                  logic'($urandom_range(0, 5) == 0),
                  logic'($urandom_range(0, 24) == 0),
                  logic'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
